charge_ctrl: RTL

Digital charge controller that sits directly upstream of the battery-charger I/O block and drives its `en` and `sel[3:0]` pins. It consumes digitised battery-voltage and battery-temperature samples (from `vsensbat` and `vbattemp`, converted by the ADC), runs a trickle → constant-current → constant-voltage → done charge sequence, and shuts the charger off on a temperature or timeout fault. All state changes are sample-driven, except start and stop, which are command-driven.

---
 rtl/charge_if.sv | 24 ++
 rtl/charge_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/charge_if.sv
// Command, sample and charger-pin bundle between the charge sequencer and its host.
interface charge_if #(parameter int ADC_W = 10);
    logic             start;
    logic             stop;
    logic [3:0]       cap_sel;
    logic             adc_valid;
    logic [ADC_W-1:0] vbat_code;
    logic [ADC_W-1:0] temp_code;
    logic             en;
    logic [3:0]       sel;
    logic [2:0]       state;
    logic             done;
    logic [1:0]       fault_code;

    modport master (
        output start, stop, cap_sel, adc_valid, vbat_code, temp_code,
        input  en, sel, state, done, fault_code
    );

    modport slave (
        input  start, stop, cap_sel, adc_valid, vbat_code, temp_code,
        output en, sel, state, done, fault_code
    );
endinterface

// File: rtl/charge_ctrl.sv
// Trickle -> CC -> CV -> DONE charge sequencer driving the charger en/sel pins.
// Optional sample-count safety timer enabled by defining CHG_SAFETY_TIMER_EN.
module charge_ctrl #(
    parameter int ADC_W        = 10,
    parameter int VBAT_PRE     = 600,
    parameter int VBAT_CV      = 840,
    parameter int VBAT_RECHG   = 800,
    parameter int TEMP_MIN     = 100,
    parameter int TEMP_MAX     = 900,
    parameter int CV_SAMPLES   = 8,
    parameter int SAFE_SAMPLES = 1000
) (
    input  logic    clk,
    input  logic    rst_n,
    charge_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRICKLE = 3'd1,
        CC      = 3'd2,
        CV      = 3'd3,
        DONE    = 3'd4,
        FAULT   = 3'd5
    } state_e;

    localparam int CVW = $clog2(CV_SAMPLES + 1);
    localparam logic [ADC_W-1:0] V_PRE   = ADC_W'(VBAT_PRE);
    localparam logic [ADC_W-1:0] V_CV    = ADC_W'(VBAT_CV);
    localparam logic [ADC_W-1:0] V_RECHG = ADC_W'(VBAT_RECHG);
    localparam logic [ADC_W-1:0] T_MIN   = ADC_W'(TEMP_MIN);
    localparam logic [ADC_W-1:0] T_MAX   = ADC_W'(TEMP_MAX);
    localparam logic [CVW-1:0]   CV_LIM  = CVW'(CV_SAMPLES);

    localparam logic [1:0] F_NONE = 2'b00;
    localparam logic [1:0] F_TEMP = 2'b01;
    localparam logic [1:0] F_SAFE = 2'b10;

    state_e     state_q, state_d;
    logic [1:0] fault_q, fault_d;
    logic [3:0] cap_q, cap_d;
    logic [1:0] tdb_q, tdb_d;
    logic [CVW-1:0] cv_q, cv_d;
    logic       en_q, done_q;
    logic [3:0] sel_q;

    logic legal, active, can_start, temp_oor, safe_hit;

    assign legal     = (state_q inside {IDLE, TRICKLE, CC, CV, DONE, FAULT});
    assign active    = (state_q inside {TRICKLE, CC, CV});
    assign can_start = (state_q inside {IDLE, DONE, FAULT});
    assign temp_oor  = (bus.temp_code < T_MIN) || (bus.temp_code > T_MAX);

`ifdef CHG_SAFETY_TIMER_EN
    logic [15:0] safe_q, safe_d, safe_nx;

    assign safe_nx  = safe_q + 16'd1;
    assign safe_hit = (safe_nx == 16'(SAFE_SAMPLES));

    always_comb begin
        safe_d = safe_q;
        if (bus.stop || !legal)
            safe_d = '0;
        else if (bus.start && can_start)
            safe_d = '0;
        else if (bus.adc_valid && active)
            safe_d = safe_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) safe_q <= '0;
        else        safe_q <= safe_d;
    end
`else
    // Parameter kept visible so both builds share one parameter list.
    assign safe_hit = 1'b0 & (SAFE_SAMPLES != 0);
`endif

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        cap_d   = cap_q;
        tdb_d   = tdb_q;
        cv_d    = cv_q;
        if (bus.stop || !legal) begin
            state_d = IDLE;
            fault_d = F_NONE;
            tdb_d   = '0;
            cv_d    = '0;
        end else if (bus.start && can_start) begin
            // Any sample strobed alongside the start is dropped here.
            state_d = TRICKLE;
            fault_d = F_NONE;
            cap_d   = bus.cap_sel;
            tdb_d   = '0;
            cv_d    = '0;
        end else if (bus.adc_valid) begin
            if (active) begin
                tdb_d = temp_oor ? ((tdb_q == 2'd3) ? tdb_q : tdb_q + 2'd1) : 2'd0;
                if (temp_oor && tdb_q != 2'd0) begin
                    state_d = FAULT;
                    fault_d = F_TEMP;
                end else if (safe_hit) begin
                    state_d = FAULT;
                    fault_d = F_SAFE;
                end else begin
                    unique case (state_q)
                        TRICKLE: if (bus.vbat_code >= V_PRE) state_d = CC;
                        CC: if (bus.vbat_code >= V_CV) begin
                            state_d = CV;
                            cv_d    = '0;
                        end
                        default: begin
                            cv_d = cv_q + 1'b1;
                            if (cv_q + 1'b1 == CV_LIM) state_d = DONE;
                        end
                    endcase
                end
            end else if (state_q == DONE && bus.vbat_code < V_RECHG) begin
                state_d = CC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fault_q <= F_NONE;
            cap_q   <= '0;
            tdb_q   <= '0;
            cv_q    <= '0;
            en_q    <= 1'b0;
            sel_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            cap_q   <= cap_d;
            tdb_q   <= tdb_d;
            cv_q    <= cv_d;
            en_q    <= (state_d inside {TRICKLE, CC, CV});
            sel_q   <= (state_d inside {CC, CV}) ? cap_d : 4'b0000;
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.en         = en_q;
    assign bus.sel        = sel_q;
    assign bus.state      = state_q;
    assign bus.done       = done_q;
    assign bus.fault_code = fault_q;
endmodule
